// File: rtl/mux16to1_registered_pkg.sv
/*------------------------------------------------------------------------------
 * Module : mux16to1_registered_pkg
 * Brief  : Shared lane-count and select-width constants for the 16:1 selector.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

package mux16to1_registered_pkg;

  localparam int N_IN  = 16;
  localparam int SEL_W = 4;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

`default_nettype wire

// File: rtl/mux16to1_registered_if.sv
/*------------------------------------------------------------------------------
 * Module : mux16to1_registered_if
 * Brief  : Lane/select/valid bundle for the registered 16:1 selector.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

interface mux16to1_registered_if
  import mux16to1_registered_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [N_IN*WIDTH-1:0] in;
  sel_t                  sel;
  logic                  in_valid;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;

  modport master (
    output in,
    output sel,
    output in_valid,
    input  out,
    input  out_valid
  );

  modport slave (
    input  in,
    input  sel,
    input  in_valid,
    output out,
    output out_valid
  );

endinterface

`default_nettype wire

// File: rtl/mux16to1_registered_leaf.sv
/*------------------------------------------------------------------------------
 * Module : mux4to1_leaf
 * Brief  : Combinational 4:1 selector of WIDTH-bit lanes; tree node of the 16:1.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module mux4to1_leaf #(
  parameter int WIDTH = 1
) (
  input  logic [4*WIDTH-1:0] i_in,
  input  logic [1:0]         i_sel,
  output logic [WIDTH-1:0]   o_out
);

  always_comb begin
    o_out = i_in[WIDTH-1:0];
    case (i_sel)
      2'd1:    o_out = i_in[2*WIDTH-1:WIDTH];
      2'd2:    o_out = i_in[3*WIDTH-1:2*WIDTH];
      2'd3:    o_out = i_in[4*WIDTH-1:3*WIDTH];
      default: o_out = i_in[WIDTH-1:0];
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux16to1_registered.sv
/*------------------------------------------------------------------------------
 * Module : mux16to1_registered
 * Brief  : 16:1 lane selector built as a two-level 4:1 tree with a registered
 *          output. Define MUX16TO1_REGISTERED_IN_REG_EN to add an input stage
 *          (latency 2 instead of 1).
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module mux16to1_registered
  import mux16to1_registered_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mux16to1_registered_if.slave        bus
);

  logic [N_IN*WIDTH-1:0] w_in;
  sel_t                  w_sel;
  logic                  w_valid;
  logic [4*WIDTH-1:0]    w_lvl1;
  logic [WIDTH-1:0]      w_mux;
  logic [WIDTH-1:0]      r_out;
  logic                  r_out_valid;

`ifdef MUX16TO1_REGISTERED_IN_REG_EN
  logic [N_IN*WIDTH-1:0] r_in;
  sel_t                  r_sel;
  logic                  r_in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in       <= '0;
      r_sel      <= '0;
      r_in_valid <= 1'b0;
    end else begin
      r_in       <= bus.in;
      r_sel      <= bus.sel;
      r_in_valid <= bus.in_valid;
    end
  end

  assign w_in    = r_in;
  assign w_sel   = r_sel;
  assign w_valid = r_in_valid;
`else
  assign w_in    = bus.in;
  assign w_sel   = bus.sel;
  assign w_valid = bus.in_valid;
`endif

  // First level: sel[1:0] picks within each group of four lanes.
  for (genvar g = 0; g < 4; g++) begin : g_leaf
    mux4to1_leaf #(
      .WIDTH (WIDTH)
    ) u_leaf (
      .i_in  (w_in[g*4*WIDTH +: 4*WIDTH]),
      .i_sel (w_sel[1:0]),
      .o_out (w_lvl1[g*WIDTH +: WIDTH])
    );
  end

  mux4to1_leaf #(
    .WIDTH (WIDTH)
  ) u_root (
    .i_in  (w_lvl1),
    .i_sel (w_sel[3:2]),
    .o_out (w_mux)
  );

  // Invalid cycles keep the last result but drop the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_valid;
      if (w_valid) begin
        r_out <= w_mux;
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux16to1_registered.sv
/*------------------------------------------------------------------------------
 * Module : tb_mux16to1_registered
 * Brief  : Self-checking bench for WIDTH=1 and WIDTH=8 instances side by side.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_mux16to1_registered;

`ifdef MUX16TO1_REGISTERED_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  in1 = '0;
  logic [127:0] in8 = '0;
  logic [3:0]   sel = '0;
  logic         vld = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference: history of (valid, selected lane) for the last two edges.
  bit         hv [2];
  logic       h1 [2];
  logic [7:0] h8 [2];
  logic       e1, ev;
  logic [7:0] e8;

  mux16to1_registered_if #(.WIDTH(1)) bus1 ();
  mux16to1_registered_if #(.WIDTH(8)) bus8 ();

  assign bus1.in       = in1;
  assign bus1.sel      = sel;
  assign bus1.in_valid = vld;
  assign bus8.in       = in8;
  assign bus8.sel      = sel;
  assign bus8.in_valid = vld;

  mux16to1_registered #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux16to1_registered #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hv[0] = 0; hv[1] = 0; h1[0] = 0; h1[1] = 0; h8[0] = 0; h8[1] = 0;
    e1 = 0; e8 = 0; ev = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_out1"}, {7'd0, bus1.out}, {7'd0, e1});
    chk({tag, "_val1"}, {7'd0, bus1.out_valid}, {7'd0, ev});
    chk({tag, "_out8"}, bus8.out, e8);
    chk({tag, "_val8"}, {7'd0, bus8.out_valid}, {7'd0, ev});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) begin
      hv[1] = hv[0]; h1[1] = h1[0]; h8[1] = h8[0];
      hv[0] = vld;
      h1[0] = in1[0 +: 1] & 1'b0 | 1'((in1 >> sel) & 16'h1);
      h8[0] = 8'((in8 >> (int'(sel) * 8)) & 128'hFF);
      ev = hv[LAT-1];
      if (ev) begin
        e1 = h1[LAT-1];
        e8 = h8[LAT-1];
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_all("rst_async");
    @(posedge clk); #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with active-looking inputs.
    in1 = 16'hFFFF; in8 = '1; sel = 4'd5; vld = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all("rst_init");
    rst_n = 1'b1;
    in1 = '0; in8 = '0; vld = 1'b0;

    // Sweep sel one per cycle over an alternating pattern.
    in1 = 16'hAAAA; vld = 1'b1;
    for (int k = 0; k < 16; k++) begin
      sel = 4'(k);
      tick("sweep");
    end
    for (int k = 0; k < 16; k++) begin
      sel = 4'(k);
      repeat (LAT) tick("sweep_s");
      chk("sweep_const", {7'd0, bus1.out}, {7'd0, 1'(k % 2)});
    end

    // One-hot walk and the neighbouring lane.
    for (int k = 0; k < 16; k++) begin
      in1 = 16'(1) << k; sel = 4'(k);
      repeat (LAT) tick("walk");
      chk("walk_hit", {7'd0, bus1.out}, 8'd1);
      sel = 4'((k + 1) % 16);
      repeat (LAT) tick("walk_n");
      chk("walk_miss", {7'd0, bus1.out}, 8'd0);
    end

    // Hold: valid drops, output keeps last value.
    in1 = 16'h0008; sel = 4'd3; vld = 1'b1;
    repeat (LAT) tick("hold_set");
    chk("hold_pre", {7'd0, bus1.out}, 8'd1);
    vld = 1'b0; in1 = '0;
    repeat (LAT) tick("hold");
    chk("hold_out", {7'd0, bus1.out}, 8'd1);
    chk("hold_val", {7'd0, bus1.out_valid}, 8'd0);

    // WIDTH=8 lane values k+0x10.
    for (int k = 0; k < 16; k++) in8[k*8 +: 8] = 8'(k + 16);
    vld = 1'b1; sel = 4'd15;
    repeat (LAT) tick("w8_15");
    chk("w8_sel15", bus8.out, 8'h1F);
    sel = 4'd0;
    repeat (LAT) tick("w8_0");
    chk("w8_sel0", bus8.out, 8'h10);

    // Randomized traffic with a reset dropped in mid-stream.
    for (int n = 0; n < 300; n++) begin
      in1 = 16'($urandom);
      in8 = {$urandom, $urandom, $urandom, $urandom};
      sel = 4'($urandom_range(0, 15));
      vld = ($urandom_range(0, 3) != 0);
      tick("rand");
      if (n == 150) begin
        async_reset();
        chk("rst_mid_out", bus8.out, 8'h00);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
